// File: rtl/an_scan_ctrl.sv
// an_scan_ctrl: anode scan controller for a multiplexed 7-segment display.
// Latency: all outputs registered; en/mask/bright changes act on the next edge
//          (bright only at the next slot start).
// Backpressure: none, free-running refresh timer; en=0 parks the scan dark.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   en            scan enable; low forces IDLE (all anodes off, digit 0)
//   bright        brightness 0..15, latched at each slot start
//   blank_mask    per-digit permanent blank
//   blink_mask    per-digit blink (only when AN_SCAN_BLINK_EN is defined)
//   an_out        active-low anodes, at most one bit low
//   dig_sel       current digit index for the segment mux
//   frame_tick    one-cycle pulse after the digit index wraps to 0
//
// Optional feature macro: AN_SCAN_BLINK_EN (adds blink_mask and blink timer).
module an_scan_ctrl #(
  parameter int N_DIG        = 8,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYC    = 64,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [3:0]                 bright,
  input  logic [N_DIG-1:0]           blank_mask,
`ifdef AN_SCAN_BLINK_EN
  input  logic [N_DIG-1:0]           blink_mask,
`endif
  output logic [N_DIG-1:0]           an_out,
  output logic [$clog2(N_DIG)-1:0]   dig_sel,
  output logic                       frame_tick
);

  localparam int DW = $clog2(N_DIG);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [31:0] BLANK_W = 32'(BLANK_CYC);
  localparam logic [31:0] STEP_W  = 32'((PRESCALE - BLANK_CYC) / 16);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DIG_LAST  = DW'(N_DIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    ON   = 2'd2,
    OFF  = 2'd3
  } state_t;

  // With no dead time a slot opens directly in ON.
  localparam state_t SLOT_FIRST = (BLANK_CYC == 0) ? ON : DEAD;

  state_t          state, state_nxt;
  logic [PW-1:0]   pcnt, pcnt_nxt;
  logic [DW-1:0]   dig_nxt;
  logic [3:0]      bright_q;
  logic            slot_start;
  logic            frame_wrap;
  logic [31:0]     on_end;
  logic            masked_nxt;
  logic [N_DIG-1:0] an_nxt;

`ifdef AN_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_phase, blink_phase_nxt;
  logic          blink_roll;

  // The phase flips on the same edge that completes the BLINK_FRAMES-th frame,
  // so the first slot of the new frame already sees the new phase.
  assign blink_roll      = frame_wrap && (blink_cnt == BW'(BLINK_FRAMES - 1));
  assign blink_phase_nxt = blink_phase ^ blink_roll;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_wrap) begin
      blink_cnt   <= blink_roll ? '0 : blink_cnt + BW'(1);
      blink_phase <= blink_phase_nxt;
    end
  end

  assign masked_nxt = blank_mask[dig_nxt] | (blink_mask[dig_nxt] & blink_phase_nxt);
`else
  assign masked_nxt = blank_mask[dig_nxt];
`endif

  // End of the lit window; at bright=15 this equals PRESCALE and is never hit,
  // so ON runs to the slot wrap.
  assign on_end = BLANK_W + (32'(bright_q) + 32'd1) * STEP_W;

  always_comb begin
    state_nxt  = state;
    pcnt_nxt   = pcnt;
    dig_nxt    = dig_sel;
    slot_start = 1'b0;
    frame_wrap = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      pcnt_nxt  = '0;
      dig_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt  = SLOT_FIRST;
          pcnt_nxt   = '0;
          dig_nxt    = '0;
          slot_start = 1'b1;
        end
        default: begin
          if (pcnt == PCNT_LAST) begin
            state_nxt  = SLOT_FIRST;
            pcnt_nxt   = '0;
            slot_start = 1'b1;
            if (dig_sel == DIG_LAST) begin
              dig_nxt    = '0;
              frame_wrap = 1'b1;
            end else begin
              dig_nxt = dig_sel + DW'(1);
            end
          end else begin
            pcnt_nxt = pcnt + PW'(1);
            case (state)
              DEAD:    if (32'(pcnt_nxt) >= BLANK_W) state_nxt = ON;
              ON:      if (32'(pcnt_nxt) == on_end)  state_nxt = OFF;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Anodes are decoded from the next state so they switch on the same edge
  // as dig_sel, keeping the segment mux and anode aligned.
  always_comb begin
    an_nxt = '1;
    if (state_nxt == ON && !masked_nxt) an_nxt[dig_nxt] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pcnt       <= '0;
      dig_sel    <= '0;
      an_out     <= '1;
      frame_tick <= 1'b0;
      bright_q   <= '0;
    end else begin
      state      <= state_nxt;
      pcnt       <= pcnt_nxt;
      dig_sel    <= dig_nxt;
      an_out     <= an_nxt;
      frame_tick <= frame_wrap;
      if (slot_start) bright_q <= bright;
    end
  end

endmodule

// File: doc/an_scan_ctrl.md
# an_scan_ctrl

Parametrised anode scan controller for the multiplexed 7-segment display, replacing the fixed 8-digit anode decoder plus external refresh counter. It generates its own refresh timing and drives one active-low anode per digit. It exports the current digit index so the segment mux can select matching data. It adds per-digit blanking, 16-level brightness, an anti-ghosting dead time and an optional blink function for time-set mode.

## Interface
- `N_DIG`, 8, number of digits/anodes (2..16).
- `PRESCALE`, 100000, clock cycles per digit slot (≥ BLANK_CYC+16).
- `BLANK_CYC`, 64, dead-time cycles at slot start with all anodes off; (PRESCALE−BLANK_CYC) must be divisible by 16.
- `BLINK_FRAMES`, 256, full scan frames per blink half-period (only with BLINK_EN).
- `clk` in 1 system clock.
- `rst` in 1 asynchronous, active-high reset.
- `en` in 1 scan enable; 0 forces display dark.
- `bright` in 4 brightness level 0..15; sampled at slot start.
- `blank_mask` in N_DIG 1 = digit permanently off.
- `blink_mask` in N_DIG 1 = digit blinks (port present only with BLINK_EN).
- `an_out` out N_DIG registered active-low anodes; at most one bit low.
- `dig_sel` out $clog2(N_DIG) registered current digit index, to segment mux.
- `frame_tick` out 1 one-cycle pulse at each frame wrap.

## Operation
- Slot counter `pcnt` counts 0..PRESCALE−1 and wraps; digit index advances by one on wrap, N_DIG−1 → 0.
- Localparam STEP = (PRESCALE−BLANK_CYC)/16; on-window length = (bright_q+1)·STEP, with bright_q latched when pcnt==0.
- FSM states: IDLE, DEAD, ON, OFF.
- IDLE: an_out all 1, pcnt=0, dig_sel=0; en=1 → DEAD.
- DEAD: anodes off while pcnt < BLANK_CYC → ON. If BLANK_CYC=0, DEAD lasts 0 cycles and the slot begins in ON.
- ON: an_out[dig_sel]=0 unless the digit is masked; pcnt reaching BLANK_CYC+(bright_q+1)·STEP → OFF.
- OFF: anodes off until slot wrap → DEAD with the next digit.
- At bright=15, OFF is never entered: ON runs to wrap.
- Digit is masked if blank_mask[dig_sel]=1, or (BLINK_EN) blink_mask[dig_sel]=1 while blink_phase=1.
- A masked digit keeps its full slot timing; only its anode stays high.
- `en`=0 in any state → IDLE on the next edge. It takes priority over wrap.
- blank_mask and blink_mask are combinational into the anode register; a change takes effect on the next edge.
- bright is only honoured at the next slot start.

## Timing
- Reset values: an_out = all 1, dig_sel = 0, frame_tick = 0, pcnt = 0, state = IDLE, blink_phase = 0, blink counter = 0.
- First slot after reset: en=1 at edge k gives state DEAD, pcnt=0 at k+1. Anode 0 goes low at edge k+1+BLANK_CYC.
- an_out and dig_sel change on the same edge; dig_sel updates at the DEAD entry. The segment mux therefore has BLANK_CYC cycles to settle before the anode turns on.
- frame_tick is high for the cycle following the edge where dig_sel wraps to 0.
- Slot length is exactly PRESCALE cycles, and a frame is exactly N_DIG·PRESCALE cycles, independent of bright and masks.

## Configuration
- `AN_SCAN_BLINK_EN` defined:
  - `blink_mask` port exists.
  - A frame counter toggles blink_phase every BLINK_FRAMES frame_ticks.
  - Blinking digits are dark while blink_phase=1.
- Undefined: no blink_mask port, no blink counter, blink_phase is constant 0.

## Test plan
Bench parameters: N_DIG=4, PRESCALE=20, BLANK_CYC=4 (STEP=1), BLINK_FRAMES=2.
- Reset, then en=1, bright=15 → an_out sequence per slot: 1111 ×4 cycles, then low bit for 16 cycles. The low bit steps through 1110, 1101, 1011, 0111. frame_tick pulses every 80 cycles.
- bright=3 → each digit is low for exactly 4 cycles (pcnt 4..7) and dark for pcnt 8..19. Changing bright mid-slot alters only the next slot.
- blank_mask=4'b0100 → digit 2 never low, while its slot still lasts 20 cycles with dig_sel=2.
- en deasserted at pcnt=10 of digit 1 → next edge an_out=1111, dig_sel=0. Re-enable restarts at digit 0, DEAD.
- rst asserted mid-ON → an_out=1111 and dig_sel=0 immediately, without waiting for a clock edge.
- (AN_SCAN_BLINK_EN) blink_mask=4'b0001 → digit 0 lit in frames 0–1, dark in frames 2–3, lit again in frames 4–5.
